// File: rtl/conv2d_sequencer_pkg.sv
// conv2d_sequencer_pkg: shared state encoding and arithmetic helpers for the convolution sequencer
package conv2d_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;
  function automatic int out_dim(input int in_sz, input int k, input int stride);
    return (in_sz - k) / stride + 1;
  endfunction
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int dw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = ~hi;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/conv2d_sequencer_if.sv
// conv2d_sequencer_if: control handshake plus memory-side buses of the convolution sequencer
interface conv2d_sequencer_if #(
  parameter int DW  = 8,
  parameter int IAW = 5,
  parameter int KAW = 4,
  parameter int OAW = 4
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [IAW-1:0]        in_addr;
  logic signed [DW-1:0]  in_data;
  logic [KAW-1:0]        kern_addr;
  logic signed [DW-1:0]  kern_data;
  logic [OAW-1:0]        out_addr;
  logic signed [DW-1:0]  out_data;
  logic                  out_we;
  modport master (
    input  start, in_data, kern_data,
    output busy, done, in_addr, kern_addr, out_addr, out_data, out_we
  );
  modport slave (
    output start, in_data, kern_data,
    input  busy, done, in_addr, kern_addr, out_addr, out_data, out_we
  );
endinterface

// File: rtl/conv2d_sequencer_mac.sv
// conv2d_sequencer_mac: registered signed multiply-accumulate with clear and enable
module conv2d_sequencer_mac #(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  output logic signed [AW-1:0] o_acc
);
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   r_acc;
  assign w_prod = i_a * i_b;
  assign o_acc  = r_acc;
  // clear wins over accumulate so the first tap starts a fresh sum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en) r_acc <= r_acc + AW'(w_prod);
  end
endmodule

// File: rtl/conv2d_sequencer.sv
// conv2d_sequencer: walks output positions and kernel taps, driving one shared MAC and the memories
module conv2d_sequencer
  import conv2d_sequencer_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int INPUT_ROWS  = 5,
  parameter int INPUT_COLS  = 5,
  parameter int KERNEL_ROWS = 3,
  parameter int KERNEL_COLS = 3,
  parameter int STRIDE      = 1
) (
  input logic clk,
  input logic reset,
  conv2d_sequencer_if.master bus
);
  localparam int OUT_ROWS = out_dim(INPUT_ROWS, KERNEL_ROWS, STRIDE);
  localparam int OUT_COLS = out_dim(INPUT_COLS, KERNEL_COLS, STRIDE);
  localparam int K        = KERNEL_ROWS * KERNEL_COLS;
  localparam int ACC_W    = 2 * DATA_SIZE + $clog2(K);
  localparam int IAW      = $clog2(INPUT_ROWS * INPUT_COLS);
  localparam int KAW      = $clog2(K);
  localparam int OAW      = $clog2(OUT_ROWS * OUT_COLS);
  localparam int ORW      = $clog2(OUT_ROWS + 1);
  localparam int OCW      = $clog2(OUT_COLS + 1);
  localparam int KRW      = $clog2(KERNEL_ROWS + 1);
  localparam int KCW      = $clog2(KERNEL_COLS + 1);
  state_t                   r_state, w_nx_state;
  logic [ORW-1:0]           r_orow, w_nx_orow;
  logic [OCW-1:0]           r_ocol, w_nx_ocol;
  logic [KRW-1:0]           r_kr, w_nx_kr;
  logic [KCW-1:0]           r_kc, w_nx_kc;
  logic [IAW-1:0]           r_in_addr, w_in_nx;
  logic [KAW-1:0]           r_kern_addr, w_kern_nx;
  logic                     w_kc_last, w_kr_last, w_oc_last, w_or_last;
  logic signed [ACC_W-1:0]  w_acc;
  assign w_kc_last = r_kc == KCW'(KERNEL_COLS - 1);
  assign w_kr_last = r_kr == KRW'(KERNEL_ROWS - 1);
  assign w_oc_last = r_ocol == OCW'(OUT_COLS - 1);
  assign w_or_last = r_orow == ORW'(OUT_ROWS - 1);
  assign w_in_nx   = IAW'((int'(w_nx_orow) * STRIDE + int'(w_nx_kr)) * INPUT_COLS
                          + int'(w_nx_ocol) * STRIDE + int'(w_nx_kc));
  assign w_kern_nx = KAW'(int'(w_nx_kr) * KERNEL_COLS + int'(w_nx_kc));
  // state, counters, and tap addresses; addresses only move when the next cycle is a RUN tap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_orow      <= '0;
      r_ocol      <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_in_addr   <= '0;
      r_kern_addr <= '0;
    end else begin
      r_state <= w_nx_state;
      r_orow  <= w_nx_orow;
      r_ocol  <= w_nx_ocol;
      r_kr    <= w_nx_kr;
      r_kc    <= w_nx_kc;
      if (w_nx_state == RUN) begin
        r_in_addr   <= w_in_nx;
        r_kern_addr <= w_kern_nx;
      end
    end
  end
  // next state and counter advance: kc fastest within a position, ocol fastest across positions
  always_comb begin
    w_nx_state = r_state;
    w_nx_orow  = r_orow;
    w_nx_ocol  = r_ocol;
    w_nx_kr    = r_kr;
    w_nx_kc    = r_kc;
    case (r_state)
      IDLE: begin
        w_nx_state = bus.start ? RUN : IDLE;
        w_nx_orow  = '0;
        w_nx_ocol  = '0;
        w_nx_kr    = '0;
        w_nx_kc    = '0;
      end
      RUN: begin
        w_nx_kc    = w_kc_last ? '0 : r_kc + KCW'(1);
        w_nx_kr    = !w_kc_last ? r_kr : w_kr_last ? '0 : r_kr + KRW'(1);
        w_nx_state = (w_kc_last && w_kr_last) ? DRAIN : RUN;
      end
      DRAIN: w_nx_state = WRITE;
      WRITE: begin
        w_nx_ocol  = w_oc_last ? '0 : r_ocol + OCW'(1);
        w_nx_orow  = !w_oc_last ? r_orow : w_or_last ? '0 : r_orow + ORW'(1);
        w_nx_state = (w_oc_last && w_or_last) ? DONE : RUN;
      end
      DONE: w_nx_state = IDLE;
      default: w_nx_state = IDLE;
    endcase
  end
  // memory data lags the address by one cycle, so the product accumulated in a cycle belongs to the previous tap
  conv2d_sequencer_mac #(.DW(DATA_SIZE), .AW(ACC_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .i_clr (r_state == RUN && r_kr == '0 && r_kc == '0),
    .i_en  (r_state == RUN || r_state == DRAIN),
    .i_a   (bus.in_data),
    .i_b   (bus.kern_data),
    .o_acc (w_acc)
  );
  assign bus.busy      = r_state == RUN || r_state == DRAIN || r_state == WRITE;
  assign bus.done      = r_state == DONE;
  assign bus.out_we    = r_state == WRITE;
  assign bus.in_addr   = r_in_addr;
  assign bus.kern_addr = r_kern_addr;
  assign bus.out_addr  = OAW'(int'(r_orow) * OUT_COLS + int'(r_ocol));
  assign bus.out_data  = DATA_SIZE'(sat(32'(w_acc), DATA_SIZE));
endmodule

// File: tb/tb_conv2d_sequencer.sv
// tb_conv2d_sequencer: directed runs with a write scoreboard checked by an independent monitor
module tb_conv2d_sequencer;
  typedef struct {int a; int d;} wr_t;
  typedef int vec9_t [9];
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  conv2d_sequencer_if #(.DW(8), .IAW(5), .KAW(4), .OAW(4)) bus ();
  conv2d_sequencer dut (.clk(clk), .reset(rst), .bus(bus));
  logic signed [7:0] in_mem [25];
  logic signed [7:0] kern_mem [9];
  wr_t   exp_q [$];
  wr_t   mon_e;
  vec9_t t1_exp = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    n_done = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // input RAM and kernel ROM with one-cycle read latency
  always @(posedge clk) begin
    bus.in_data   <= in_mem[bus.in_addr];
    bus.kern_data <= kern_mem[bus.kern_addr];
  end
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  // monitor: every write strobe pops the next expected write
  always @(negedge clk) begin
    if (bus.done) n_done++;
    if (bus.out_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", int'(bus.out_addr), -1);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", int'(bus.out_addr), mon_e.a);
        chk("wr_data", int'(bus.out_data), mon_e.d);
      end
    end
  end
  task automatic fill(input int iv, input int kv);
    for (int i = 0; i < 25; i++) in_mem[i] = 8'(iv);
    for (int i = 0; i < 9; i++) kern_mem[i] = 8'(kv);
  endtask
  task automatic ramp_centre();
    for (int i = 0; i < 25; i++) in_mem[i] = 8'(i);
    for (int i = 0; i < 9; i++) kern_mem[i] = 8'(i == 4 ? 1 : 0);
  endtask
  task automatic push9(input vec9_t v);
    for (int i = 0; i < 9; i++) exp_q.push_back('{i, v[i]});
  endtask
  task automatic push_all(input int v);
    for (int i = 0; i < 9; i++) exp_q.push_back('{i, v});
  endtask
  // one start pulse; optionally re-pulse start or assert reset at a given cycle of the run
  task automatic run(input int pulse_at, input int rst_at, input int exp_lat);
    int s, c, lat, nd0;
    nd0 = n_done;
    lat = -1;
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc + 1;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      @(negedge clk);
      c = cyc - s + 1;
      bus.start = (c == pulse_at);
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.out_we, 0);
        chk("rst_in_addr", int'(bus.in_addr), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_done_count", n_done - nd0, 0);
        return;
      end
      if (bus.done) lat = c;
    end
    chk("done_latency", lat, exp_lat);
    @(negedge clk);
    chk("done_width", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    chk("done_count", n_done - nd0, 1);
    chk("writes_left", exp_q.size(), 0);
  endtask
  initial begin
    int s, c, d1, d2, d3, br, nd0;
    bus.start = 1'b0;
    fill(0, 0);
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_we", bus.out_we, 0);
    chk("reset_in_addr", int'(bus.in_addr), 0);
    chk("reset_kern_addr", int'(bus.kern_addr), 0);
    chk("reset_out_addr", int'(bus.out_addr), 0);
    chk("reset_out_data", int'(bus.out_data), 0);
    rst = 1'b0;
    ramp_centre();
    push9(t1_exp);
    run(0, 0, 100);
    fill(1, 1);
    push_all(9);
    run(0, 0, 100);
    fill(127, 127);
    push_all(127);
    run(0, 0, 100);
    fill(-128, 127);
    push_all(-128);
    run(0, 0, 100);
    fill(1, 1);
    push_all(9);
    run(40, 0, 100);
    ramp_centre();
    push9(t1_exp);
    run(0, 30, 100);
    push9(t1_exp);
    run(0, 0, 100);
    fill(1, 1);
    repeat (3) push_all(9);
    nd0 = n_done;
    d1 = -1;
    d2 = -1;
    d3 = -1;
    br = -1;
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc + 1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      c = cyc - s + 1;
      if (bus.done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (d1 > 0 && br < 0 && c > d1 && bus.busy) br = c;
    end
    bus.start = 1'b0;
    for (int i = 0; i < 200 && d3 < 0; i++) begin
      @(negedge clk);
      if (bus.done) d3 = cyc - s + 1;
    end
    chk("held_first_done", d1, 100);
    chk("held_rerun_busy", br, 102);
    chk("held_second_done", d2, 201);
    chk("held_third_done", d3, 302);
    repeat (2) @(negedge clk);
    chk("held_done_count", n_done - nd0, 3);
    chk("held_writes_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
